bp_me_lce_cord_sequencer: RTL and testbench
===========================================

Name: bp_me_lce_cord_sequencer

Overview:
- Takes an LCE-id bitmask, for example a sharers vector for an invalidate, and emits one destination per cycle, each carrying an LCE id, a coherence-NoC coordinate and a CID.
- Sits in the CCE/ME command path ahead of the LCE command packet builder.
- Scans the mask round-robin, starting just after the requesting LCE. The requester can optionally be excluded from the mask.
- Reports a completion pulse with the number of destinations emitted.

Parameters:
- bp_params_p, e_bp_default_cfg: processor config. Supplies lce_id_width_p, coh_noc_cord_width_p and coh_noc_cid_width_p.
- num_lce_p, derived from bp_params_p: total LCE count = mask width. Not required to be a power of two.
- cnt_width_lp, `BSG_WIDTH(num_lce_p): width of the destination count.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  1  request valid.
- req_ready_and_o  out  1  request ready; a request is accepted on v & ready.
- req_mask_i  in  num_lce_p  target LCEs.
- req_lce_id_i  in  lce_id_width_p  requesting LCE; defines the scan start.
- req_exclude_i  in  1  if set, clear bit req_lce_id_i from the mask.
- dest_v_o  out  1  destination valid.
- dest_ready_and_i  in  1  downstream ready.
- dest_lce_id_o  out  lce_id_width_p  current destination id.
- dest_cord_o  out  coh_noc_cord_width_p  NoC coordinate of dest_lce_id_o.
- dest_cid_o  out  coh_noc_cid_width_p  CID of dest_lce_id_o.
- dest_last_o  out  1  the current destination is the final one.
- done_v_o  out  1  one-cycle completion pulse.
- done_count_o  out  cnt_width_lp  destinations emitted; valid with done_v_o.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset state:
  - State is e_idle; pending mask, start pointer and count are all 0.
  - req_ready_and_o=1.
  - dest_v_o=0, dest_last_o=0, done_v_o=0, done_count_o=0.
  - dest_lce_id_o, dest_cord_o and dest_cid_o are 0.
- Reset mid-operation aborts the request: pending destinations are dropped and no done_v_o pulse is produced.
- FSM states: e_idle, e_send, e_done.
- e_idle:
  - req_ready_and_o=1.
  - On accept:
    - pending = req_mask_i & ~(req_exclude_i ? onehot(req_lce_id_i) : 0).
    - start = (req_lce_id_i + 1) mod num_lce_p. The value wraps to 0 when req_lce_id_i = num_lce_p-1.
    - count = 0.
    - Next state is e_send if pending != 0, else e_done.
- e_send:
  - req_ready_and_o=0 and dest_v_o=1.
  - Selection: dest_lce_id_o is the first set bit of pending, scanning upward from start and wrapping past num_lce_p-1 to 0.
  - dest_cord_o and dest_cid_o are the combinational translation of dest_lce_id_o.
  - dest_last_o=1 iff popcount(pending)==1.
  - On dest_v_o & dest_ready_and_i: clear the selected bit and increment count. If dest_last_o=1, next state is e_done.
  - All dest_* outputs are derived from registers only. They must stay stable while dest_ready_and_i=0.
  - Throughput is one destination per cycle under continuous ready.
- e_done:
  - done_v_o=1 for exactly one cycle, with done_count_o = count.
  - req_ready_and_o=0.
  - Next state is e_idle.
  - done_count_o holds its value until the next accept.
- Latency:
  - Accept at cycle T gives the first dest_v_o at T+1.
  - The last handshake at cycle U gives done_v_o at U+1.
  - An empty mask gives done_v_o at T+1 with count 0.
  - A new request can be accepted at the cycle after done_v_o, i.e. back in e_idle.
- Width rules:
  - The start pointer wrap uses a compare against num_lce_p-1, not truncation, so non-power-of-two counts are handled.
  - count saturates by construction, since it is at most num_lce_p.
- Illegal input: req_lce_id_i >= num_lce_p has no defined result; an assertion flags it in simulation.

Decomposition:
- Shared package bp_me_pkg: typedef enum bp_me_lce_seq_state_e {e_idle, e_send, e_done}.
- Sub-modules:
  - bp_me_lce_id_to_cord, instantiated on dest_lce_id_o for the cord and CID translation.
  - A rotating priority encoder, using bsg_priority_encode over pending rotated by start and then un-rotated.

Test Plan:
- Basic round-robin: num_lce_p=8, mask=8'b1010_0110, req_lce_id=2, exclude=0, ready held at 1. Expected:
  - Ids 5, 7, 1, 2 emitted on consecutive cycles.
  - dest_last_o=1 only on id 2.
  - done_v_o at the cycle after, with count=4.
  - Each cord/CID matches the translation model.
- Exclusion and wrap: mask=8'hFF, req_lce_id=7, exclude=1. Expected: ids 0..6 in order, count=7.
- Empty mask: mask=8'h04, req_lce_id=2, exclude=1. Expected:
  - No dest_v_o.
  - done_v_o at T+1 with count=0.
  - req_ready_and_o=1 again at T+2.
- Backpressure: hold dest_ready_and_i=0 for 5 cycles mid-stream. Expected:
  - dest_* outputs stable throughout the stall.
  - No id skipped or duplicated.
  - Count is correct at the end.
- Reset mid-operation: assert reset_i after 2 of 4 handshakes. Expected:
  - The next cycle shows all reset values.
  - No done_v_o pulse.
  - A new request is accepted normally afterwards.
- Back-to-back requests: two single-bit requests with req_v_i held high. Expected:
  - The second request is accepted exactly in the cycle after the first done_v_o.
  - done_count_o=1 for each.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared ME types: sequencer FSM encoding and the default coherence-network geometry.
package bp_me_pkg;

  typedef enum logic [1:0] {e_idle, e_send, e_done} bp_me_lce_seq_state_e;

  // Default config: 8 LCEs, I$/D$ pairs per tile, tiles laid out on a 2-wide mesh.
  localparam int default_num_lce_lp              = 8;
  localparam int default_lce_id_width_lp         = 3;
  localparam int default_lces_per_tile_lp        = 2;
  localparam int default_coh_noc_x_dim_lp        = 2;
  localparam int default_coh_noc_x_cord_width_lp = 2;
  localparam int default_coh_noc_cord_width_lp   = 4;
  localparam int default_coh_noc_cid_width_lp    = 1;

endpackage

// File: rtl/bp_me_lce_id_to_cord.sv
// Translates an LCE id into its coherence-NoC coordinate {y,x} and CID within the tile.
module bp_me_lce_id_to_cord
  import bp_me_pkg::*;
#(
  parameter int lce_id_width_p         = default_lce_id_width_lp,
  parameter int coh_noc_cord_width_p   = default_coh_noc_cord_width_lp,
  parameter int coh_noc_cid_width_p    = default_coh_noc_cid_width_lp,
  parameter int coh_noc_x_dim_p        = default_coh_noc_x_dim_lp,
  parameter int coh_noc_x_cord_width_p = default_coh_noc_x_cord_width_lp,
  parameter int lces_per_tile_p        = default_lces_per_tile_lp
) (
  input  logic [lce_id_width_p-1:0]       lce_id_i,
  output logic [coh_noc_cord_width_p-1:0] cord_o,
  output logic [coh_noc_cid_width_p-1:0]  cid_o
);

  localparam int y_cord_width_lp = coh_noc_cord_width_p - coh_noc_x_cord_width_p;

  int tile_id;
  int tile_x;
  int tile_y;

  always_comb begin
    tile_id = int'(lce_id_i) / lces_per_tile_p;
    tile_x  = tile_id % coh_noc_x_dim_p;
    tile_y  = tile_id / coh_noc_x_dim_p;
    cord_o  = {y_cord_width_lp'(tile_y), coh_noc_x_cord_width_p'(tile_x)};
    cid_o   = coh_noc_cid_width_p'(int'(lce_id_i) % lces_per_tile_p);
  end

endmodule

// File: rtl/bp_me_lce_rr_encode.sv
// Rotating priority encoder: lowest set bit of v_i at or above start_i, wrapping modulo width_p.
module bp_me_lce_rr_encode #(
  parameter int width_p    = 8,
  parameter int id_width_p = 3
) (
  input  logic [width_p-1:0]    v_i,
  input  logic [id_width_p-1:0] start_i,
  output logic [id_width_p-1:0] id_o
);

  logic [2*width_p-1:0] v_dbl;
  logic [width_p-1:0]   v_rot;
  logic [id_width_p-1:0] rot_idx;
  logic [id_width_p:0]  abs_idx;
  logic                 found;

  always_comb begin
    // Doubling the vector lets a plain shift rotate correctly for any width, power of two or not.
    v_dbl   = {v_i, v_i} >> start_i;
    v_rot   = v_dbl[width_p-1:0];
    rot_idx = '0;
    found   = 1'b0;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (v_rot[i]) begin
        rot_idx = id_width_p'(i);
        found   = 1'b1;
      end
    end
    abs_idx = {1'b0, start_i} + {1'b0, rot_idx};
    if (abs_idx >= (id_width_p + 1)'(width_p))
      abs_idx = abs_idx - (id_width_p + 1)'(width_p);
    id_o = found ? abs_idx[id_width_p-1:0] : '0;
  end

endmodule

// File: rtl/bp_me_lce_cord_sequencer.sv
// Expands an LCE bitmask into one destination per cycle, round-robin from just past the requester.
module bp_me_lce_cord_sequencer
  import bp_me_pkg::*;
#(
  parameter int num_lce_p              = default_num_lce_lp,
  parameter int lce_id_width_p         = default_lce_id_width_lp,
  parameter int coh_noc_cord_width_p   = default_coh_noc_cord_width_lp,
  parameter int coh_noc_cid_width_p    = default_coh_noc_cid_width_lp,
  parameter int cnt_width_lp           = $clog2(num_lce_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            req_v_i,
  output logic                            req_ready_and_o,
  input  logic [num_lce_p-1:0]            req_mask_i,
  input  logic [lce_id_width_p-1:0]       req_lce_id_i,
  input  logic                            req_exclude_i,
  output logic                            dest_v_o,
  input  logic                            dest_ready_and_i,
  output logic [lce_id_width_p-1:0]       dest_lce_id_o,
  output logic [coh_noc_cord_width_p-1:0] dest_cord_o,
  output logic [coh_noc_cid_width_p-1:0]  dest_cid_o,
  output logic                            dest_last_o,
  output logic                            done_v_o,
  output logic [cnt_width_lp-1:0]         done_count_o
);

  bp_me_lce_seq_state_e state_r, state_n;
  logic [num_lce_p-1:0]      pending_r;
  logic [lce_id_width_p-1:0] start_r;
  logic [cnt_width_lp-1:0]   count_r;

  logic                      accept;
  logic                      send_hs;
  logic                      pending_single;
  logic [num_lce_p-1:0]      req_onehot;
  logic [num_lce_p-1:0]      req_pending;
  logic [lce_id_width_p-1:0] req_start;

  assign accept         = req_v_i & req_ready_and_o;
  assign send_hs        = dest_v_o & dest_ready_and_i;
  assign req_onehot     = num_lce_p'(1) << req_lce_id_i;
  assign req_pending    = req_mask_i & ~(req_exclude_i ? req_onehot : '0);
  assign req_start      = (req_lce_id_i == lce_id_width_p'(num_lce_p - 1)) ? '0 : req_lce_id_i + 1'b1;
  assign pending_single = (pending_r != '0) && ((pending_r & (pending_r - 1'b1)) == '0);

  bp_me_lce_rr_encode #(
    .width_p    (num_lce_p),
    .id_width_p (lce_id_width_p)
  ) rr_encode (
    .v_i     (pending_r),
    .start_i (start_r),
    .id_o    (dest_lce_id_o)
  );

  bp_me_lce_id_to_cord #(
    .lce_id_width_p       (lce_id_width_p),
    .coh_noc_cord_width_p (coh_noc_cord_width_p),
    .coh_noc_cid_width_p  (coh_noc_cid_width_p)
  ) id_to_cord (
    .lce_id_i (dest_lce_id_o),
    .cord_o   (dest_cord_o),
    .cid_o    (dest_cid_o)
  );

  always_comb begin
    state_n         = state_r;
    req_ready_and_o = 1'b0;
    dest_v_o        = 1'b0;
    dest_last_o     = 1'b0;
    done_v_o        = 1'b0;
    case (state_r)
      e_idle: begin
        req_ready_and_o = 1'b1;
        if (req_v_i)
          state_n = (req_pending != '0) ? e_send : e_done;
      end
      e_send: begin
        dest_v_o    = 1'b1;
        dest_last_o = pending_single;
        if (dest_ready_and_i && pending_single)
          state_n = e_done;
      end
      e_done: begin
        done_v_o = 1'b1;
        state_n  = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  assign done_count_o = count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      pending_r <= '0;
      start_r   <= '0;
      count_r   <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        pending_r <= req_pending;
        start_r   <= req_start;
        count_r   <= '0;
      end else if (send_hs) begin
        pending_r <= pending_r & ~(num_lce_p'(1) << dest_lce_id_o);
        count_r   <= count_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && accept)
      assert ({1'b0, req_lce_id_i} < (lce_id_width_p + 1)'(num_lce_p));
  end

endmodule

// File: tb/tb_bp_me_lce_cord_sequencer.sv
// Directed bench for the LCE cord sequencer with a 8-LCE, 2-wide-mesh geometry.
module tb_bp_me_lce_cord_sequencer;

  logic       clk;
  logic       reset_i;
  logic       req_v_i;
  logic       req_ready_and_o;
  logic [7:0] req_mask_i;
  logic [2:0] req_lce_id_i;
  logic       req_exclude_i;
  logic       dest_v_o;
  logic       dest_ready_and_i;
  logic [2:0] dest_lce_id_o;
  logic [3:0] dest_cord_o;
  logic [0:0] dest_cid_o;
  logic       dest_last_o;
  logic       done_v_o;
  logic [3:0] done_count_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bp_me_lce_cord_sequencer dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_v_i          (req_v_i),
    .req_ready_and_o  (req_ready_and_o),
    .req_mask_i       (req_mask_i),
    .req_lce_id_i     (req_lce_id_i),
    .req_exclude_i    (req_exclude_i),
    .dest_v_o         (dest_v_o),
    .dest_ready_and_i (dest_ready_and_i),
    .dest_lce_id_o    (dest_lce_id_o),
    .dest_cord_o      (dest_cord_o),
    .dest_cid_o       (dest_cid_o),
    .dest_last_o      (dest_last_o),
    .done_v_o         (done_v_o),
    .done_count_o     (done_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile = id/2 on a 2-wide mesh: x = tile bit0, y = tile bit1; CID selects I$/D$.
  function automatic logic [3:0] exp_cord(input int l);
    return 4'((((l >> 2) & 3) << 2) | ((l >> 1) & 1));
  endfunction

  function automatic logic [0:0] exp_cid(input int l);
    return 1'(l & 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; req_v_i = 1'b0; req_mask_i = '0; req_lce_id_i = '0;
    req_exclude_i = 1'b0; dest_ready_and_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    total_cnt++; if (req_ready_and_o !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready_and_o); else pass_cnt++;
    total_cnt++; if ({dest_v_o, dest_last_o, done_v_o} !== 3'b000) $display("FAIL reset_valids got %b want 000", {dest_v_o, dest_last_o, done_v_o}); else pass_cnt++;
    total_cnt++; if (done_count_o !== 4'd0) $display("FAIL reset_count got %0d want 0", done_count_o); else pass_cnt++;
    total_cnt++; if ({dest_lce_id_o, dest_cord_o, dest_cid_o} !== 8'h00) $display("FAIL reset_dest got %h want 00", {dest_lce_id_o, dest_cord_o, dest_cid_o}); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int ids [4] = '{5, 7, 1, 2};
    req_v_i = 1'b1; req_mask_i = 8'b1010_0110; req_lce_id_i = 3'd2; req_exclude_i = 1'b0;
    dest_ready_and_i = 1'b1;
    step();
    req_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'(ids[k])) $display("FAIL rr_id[%0d] got v=%b id=%0d want v=1 id=%0d", k, dest_v_o, dest_lce_id_o, ids[k]); else pass_cnt++;
      total_cnt++; if (dest_cord_o !== exp_cord(ids[k]) || dest_cid_o !== exp_cid(ids[k])) $display("FAIL rr_cord[%0d] got %h/%b want %h/%b", k, dest_cord_o, dest_cid_o, exp_cord(ids[k]), exp_cid(ids[k])); else pass_cnt++;
      total_cnt++; if (dest_last_o !== (k == 3)) $display("FAIL rr_last[%0d] got %b want %b", k, dest_last_o, (k == 3)); else pass_cnt++;
      total_cnt++; if (req_ready_and_o !== 1'b0) $display("FAIL rr_busy[%0d] got ready=%b want 0", k, req_ready_and_o); else pass_cnt++;
      step();
    end
    total_cnt++; if (done_v_o !== 1'b1 || done_count_o !== 4'd4 || dest_v_o !== 1'b0) $display("FAIL rr_done got done=%b cnt=%0d dv=%b want 1/4/0", done_v_o, done_count_o, dest_v_o); else pass_cnt++;
    step();
    total_cnt++; if (req_ready_and_o !== 1'b1 || done_v_o !== 1'b0 || done_count_o !== 4'd4) $display("FAIL rr_idle got rdy=%b done=%b cnt=%0d want 1/0/4", req_ready_and_o, done_v_o, done_count_o); else pass_cnt++;
  endtask

  task automatic test_exclude_wrap();
    req_v_i = 1'b1; req_mask_i = 8'hFF; req_lce_id_i = 3'd7; req_exclude_i = 1'b1;
    dest_ready_and_i = 1'b1;
    step();
    req_v_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'(k) || dest_last_o !== (k == 6)) $display("FAIL wrap_id[%0d] got v=%b id=%0d last=%b want 1/%0d/%b", k, dest_v_o, dest_lce_id_o, dest_last_o, k, (k == 6)); else pass_cnt++;
      total_cnt++; if (dest_cord_o !== exp_cord(k) || dest_cid_o !== exp_cid(k)) $display("FAIL wrap_cord[%0d] got %h/%b want %h/%b", k, dest_cord_o, dest_cid_o, exp_cord(k), exp_cid(k)); else pass_cnt++;
      step();
    end
    total_cnt++; if (done_v_o !== 1'b1 || done_count_o !== 4'd7) $display("FAIL wrap_done got done=%b cnt=%0d want 1/7", done_v_o, done_count_o); else pass_cnt++;
    step();
  endtask

  task automatic test_empty_mask();
    req_v_i = 1'b1; req_mask_i = 8'h04; req_lce_id_i = 3'd2; req_exclude_i = 1'b1;
    step();
    req_v_i = 1'b0;
    total_cnt++; if (dest_v_o !== 1'b0 || done_v_o !== 1'b1 || done_count_o !== 4'd0) $display("FAIL empty_done got dv=%b done=%b cnt=%0d want 0/1/0", dest_v_o, done_v_o, done_count_o); else pass_cnt++;
    total_cnt++; if (req_ready_and_o !== 1'b0) $display("FAIL empty_busy got ready=%b want 0", req_ready_and_o); else pass_cnt++;
    step();
    total_cnt++; if (req_ready_and_o !== 1'b1 || done_v_o !== 1'b0 || dest_v_o !== 1'b0) $display("FAIL empty_idle got rdy=%b done=%b dv=%b want 1/0/0", req_ready_and_o, done_v_o, dest_v_o); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int ids [4] = '{6, 0, 1, 3};
    req_v_i = 1'b1; req_mask_i = 8'b0100_1011; req_lce_id_i = 3'd4; req_exclude_i = 1'b0;
    dest_ready_and_i = 1'b1;
    step();
    req_v_i = 1'b0;
    total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'd6) $display("FAIL bp_first got v=%b id=%0d want 1/6", dest_v_o, dest_lce_id_o); else pass_cnt++;
    step();
    dest_ready_and_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'd0 || dest_last_o !== 1'b0 || dest_cord_o !== exp_cord(0) || dest_cid_o !== exp_cid(0)) $display("FAIL bp_stall[%0d] got v=%b id=%0d last=%b cord=%h cid=%b want 1/0/0/%h/%b", c, dest_v_o, dest_lce_id_o, dest_last_o, dest_cord_o, dest_cid_o, exp_cord(0), exp_cid(0)); else pass_cnt++;
      step();
    end
    dest_ready_and_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'(ids[k]) || dest_last_o !== (k == 3)) $display("FAIL bp_id[%0d] got v=%b id=%0d last=%b want 1/%0d/%b", k, dest_v_o, dest_lce_id_o, dest_last_o, ids[k], (k == 3)); else pass_cnt++;
      step();
    end
    total_cnt++; if (done_v_o !== 1'b1 || done_count_o !== 4'd4) $display("FAIL bp_done got done=%b cnt=%0d want 1/4", done_v_o, done_count_o); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    req_v_i = 1'b1; req_mask_i = 8'b1010_0110; req_lce_id_i = 3'd2; req_exclude_i = 1'b0;
    dest_ready_and_i = 1'b1;
    step();
    req_v_i = 1'b0;
    step(); step();
    total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'd1 || done_count_o !== 4'd2) $display("FAIL rst_pre got v=%b id=%0d cnt=%0d want 1/1/2", dest_v_o, dest_lce_id_o, done_count_o); else pass_cnt++;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    total_cnt++; if (req_ready_and_o !== 1'b1 || {dest_v_o, dest_last_o, done_v_o} !== 3'b000 || done_count_o !== 4'd0) $display("FAIL rst_state got rdy=%b flags=%b cnt=%0d want 1/000/0", req_ready_and_o, {dest_v_o, dest_last_o, done_v_o}, done_count_o); else pass_cnt++;
    total_cnt++; if ({dest_lce_id_o, dest_cord_o, dest_cid_o} !== 8'h00) $display("FAIL rst_dest got %h want 00", {dest_lce_id_o, dest_cord_o, dest_cid_o}); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++; if (done_v_o !== 1'b0 || dest_v_o !== 1'b0) $display("FAIL rst_quiet[%0d] got done=%b dv=%b want 0/0", c, done_v_o, dest_v_o); else pass_cnt++;
    end
    req_v_i = 1'b1; req_mask_i = 8'h10; req_lce_id_i = 3'd0; req_exclude_i = 1'b0;
    step();
    req_v_i = 1'b0;
    total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'd4 || dest_last_o !== 1'b1 || dest_cord_o !== exp_cord(4)) $display("FAIL rst_new got v=%b id=%0d last=%b cord=%h want 1/4/1/%h", dest_v_o, dest_lce_id_o, dest_last_o, dest_cord_o, exp_cord(4)); else pass_cnt++;
    step();
    total_cnt++; if (done_v_o !== 1'b1 || done_count_o !== 4'd1) $display("FAIL rst_new_done got done=%b cnt=%0d want 1/1", done_v_o, done_count_o); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    req_v_i = 1'b1; req_mask_i = 8'h02; req_lce_id_i = 3'd0; req_exclude_i = 1'b0;
    dest_ready_and_i = 1'b1;
    step();
    req_mask_i = 8'h40; req_lce_id_i = 3'd3;
    total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'd1 || dest_last_o !== 1'b1 || req_ready_and_o !== 1'b0) $display("FAIL b2b_a got v=%b id=%0d last=%b rdy=%b want 1/1/1/0", dest_v_o, dest_lce_id_o, dest_last_o, req_ready_and_o); else pass_cnt++;
    step();
    total_cnt++; if (done_v_o !== 1'b1 || done_count_o !== 4'd1 || req_ready_and_o !== 1'b0) $display("FAIL b2b_a_done got done=%b cnt=%0d rdy=%b want 1/1/0", done_v_o, done_count_o, req_ready_and_o); else pass_cnt++;
    step();
    total_cnt++; if (req_ready_and_o !== 1'b1 || dest_v_o !== 1'b0 || done_v_o !== 1'b0) $display("FAIL b2b_accept got rdy=%b dv=%b done=%b want 1/0/0", req_ready_and_o, dest_v_o, done_v_o); else pass_cnt++;
    step();
    req_v_i = 1'b0;
    total_cnt++; if (dest_v_o !== 1'b1 || dest_lce_id_o !== 3'd6 || dest_last_o !== 1'b1 || dest_cid_o !== exp_cid(6)) $display("FAIL b2b_b got v=%b id=%0d last=%b cid=%b want 1/6/1/%b", dest_v_o, dest_lce_id_o, dest_last_o, dest_cid_o, exp_cid(6)); else pass_cnt++;
    step();
    total_cnt++; if (done_v_o !== 1'b1 || done_count_o !== 4'd1) $display("FAIL b2b_b_done got done=%b cnt=%0d want 1/1", done_v_o, done_count_o); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_exclude_wrap();
    test_empty_mask();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
